// File: rtl/seq_divide.sv
// Iterative radix-2 restoring divider with a start/busy/done handshake.
// Divide-by-zero and signed overflow take a one-cycle fast path.
module seq_divide #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [1:0]       flag,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             div_by_zero
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [1:0]       flag_q, flag_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             dbz_q, dbz_d, done_q, done_d;

  logic             a_neg, b_neg, res_neg;
  logic [WIDTH-1:0] mag1, mag2, res;
  logic [WIDTH:0]   trial, diff;

  assign a_neg = flag[0] & in1[WIDTH-1];
  assign b_neg = flag[0] & in2[WIDTH-1];
  assign mag1  = a_neg ? -in1 : in1;
  assign mag2  = b_neg ? -in2 : in2;

  // The quotient register doubles as the dividend shifter: its MSB feeds the
  // partial remainder while the new quotient bit enters at the LSB.
  // A clear top bit of diff means no borrow, i.e. trial >= divisor.
  assign trial = {rem_q, quo_q[WIDTH-1]};
  assign diff  = trial - {1'b0, dvs_q};

  assign res_neg = flag_q[1] ? rneg_q : qneg_q;
  assign res     = flag_q[1] ? rem_q : quo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    flag_d  = flag_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    out_d   = out_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          flag_d = flag;
          qneg_d = a_neg ^ b_neg;
          rneg_d = a_neg;
          dz_d   = (in2 == '0);
          cnt_d  = '0;
          dvs_d  = mag2;
          if (in2 == '0) begin
            quo_d   = '1;
            rem_d   = in1;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_FIN;
          end else if (flag[0] && in1 == MIN_NEG && in2 == '1) begin
            quo_d   = MIN_NEG;
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = S_FIN;
          end else begin
            quo_d   = mag1;
            rem_d   = '0;
            state_d = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        rem_d = diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) state_d = S_FIN;
      end
      S_FIN: begin
        out_d   = res_neg ? -res : res;
        dbz_d   = dz_q;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      flag_q  <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      out_q   <= '0;
      dbz_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      flag_q  <= flag_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      out_q   <= out_d;
      dbz_q   <= dbz_d;
      done_q  <= done_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign out         = out_q;
  assign div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_divide.sv
// Directed bench for seq_divide: 64-bit instance for the main sequence,
// 8-bit instance for the narrow-width latency case.
module tb_seq_divide;
  logic        clk, rst;
  logic        start;
  logic [63:0] in1, in2, out;
  logic [1:0]  flag;
  logic        busy, done, dbz;
  logic        start8;
  logic [7:0]  a8, b8, o8;
  logic [1:0]  f8;
  logic        busy8, done8, dbz8;

  int nerr = 0;
  int nchk = 0;
  logic [63:0] last_out = '0;

  seq_divide #(.WIDTH(64)) u64 (
    .clk(clk), .rst(rst), .start(start), .in1(in1), .in2(in2), .flag(flag),
    .busy(busy), .done(done), .out(out), .div_by_zero(dbz)
  );

  seq_divide #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .in1(a8), .in2(b8), .flag(f8),
    .busy(busy8), .done(done8), .out(o8), .div_by_zero(dbz8)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Starts an operation in the current cycle (called #1 after an edge), so a
  // call made right after a done lands in the done cycle. intf>0 injects a
  // competing start that many cycles after acceptance.
  task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                        input logic [1:0] f, input int exp_lat, input logic [63:0] exp_out,
                        input logic exp_dz, input int intf);
    int lat;
    logic seen;
    in1 = a; in2 = b; flag = f; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk({tag, " busy"}, {63'd0, busy}, 64'd1);
    chk({tag, " hold"}, out, last_out);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (done) seen = 1'b1;
      else if (intf > 0 && lat == intf) begin
        start = 1'b1; in1 = 64'd99; in2 = 64'd9; flag = 2'd0;
      end else start = 1'b0;
    end
    start = 1'b0;
    chk({tag, " done"}, {63'd0, done}, 64'd1);
    chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, " out"}, out, exp_out);
    chk({tag, " dz"}, {63'd0, dbz}, {63'd0, exp_dz});
    chk({tag, " idle"}, {63'd0, busy}, 64'd0);
    last_out = exp_out;
  endtask

  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [1:0] f, input int exp_lat, input logic [7:0] exp_out);
    int lat;
    a8 = a; b8 = b; f8 = f; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, " done"}, {63'd0, done8}, 64'd1);
    chk({tag, " lat"}, 64'(lat), 64'(exp_lat));
    chk({tag, " out"}, {56'd0, o8}, {56'd0, exp_out});
    chk({tag, " dz"}, {63'd0, dbz8}, 64'd0);
  endtask

  initial begin
    logic any_done;
    rst = 1'b1; start = 1'b0; in1 = '0; in2 = '0; flag = '0;
    start8 = 1'b0; a8 = '0; b8 = '0; f8 = '0;
    #12;
    chk("rst busy", {63'd0, busy}, 64'd0);
    chk("rst done", {63'd0, done}, 64'd0);
    chk("rst out", out, 64'd0);
    chk("rst dz", {63'd0, dbz}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    run_op("u10/5", 64'd10, 64'd5, 2'd0, 65, 64'd2, 1'b0, 0);
    run_op("s20/-7q", 64'd20, 64'hFFFF_FFFF_FFFF_FFF9, 2'd1, 65, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 0);
    run_op("s20/-7r", 64'd20, 64'hFFFF_FFFF_FFFF_FFF9, 2'd3, 65, 64'd6, 1'b0, 0);
    run_op("u100%20", 64'd100, 64'd20, 2'd2, 65, 64'd0, 1'b0, 0);
    run_op("s5%-2", 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 2'd3, 65, 64'd1, 1'b0, 0);
    run_op("s-5%2", 64'hFFFF_FFFF_FFFF_FFFB, 64'd2, 2'd3, 65, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0);
    run_op("dz quo", 64'h1234, 64'd0, 2'd0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 0);
    run_op("dz rem", 64'h1234, 64'd0, 2'd2, 1, 64'h1234, 1'b1, 0);
    run_op("ovf quo", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1,
           64'h8000_0000_0000_0000, 1'b0, 0);
    run_op("ovf rem", 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2'd3, 1, 64'd0, 1'b0, 0);
    run_op("s-min/2", 64'h8000_0000_0000_0000, 64'd2, 2'd1, 65, 64'hC000_0000_0000_0000, 1'b0, 0);

    // competing start mid-operation, then a start in the done cycle
    run_op("ignore", 64'd10, 64'd3, 2'd0, 65, 64'd3, 1'b0, 20);
    run_op("b2b", 64'd7, 64'd2, 2'd2, 65, 64'd1, 1'b0, 0);

    // reset in the middle of an operation aborts it
    in1 = 64'd1000; in2 = 64'd7; flag = 2'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort busy", {63'd0, busy}, 64'd0);
    chk("abort out", out, 64'd0);
    chk("abort done", {63'd0, done}, 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    any_done = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      if (done) any_done = 1'b1;
    end
    chk("abort no done", {63'd0, any_done}, 64'd0);
    last_out = '0;

    run8("w8 10/5", 8'd10, 8'd5, 2'd0, 9, 8'd2);
    run8("w8 -20/7q", 8'hEC, 8'd7, 2'd1, 9, 8'hFE);
    run8("w8 -20/7r", 8'hEC, 8'd7, 2'd3, 9, 8'hFA);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
